// File: rtl/fpu_mul_if.sv
// Command handshake and operand/result bus shared by the FPU arithmetic units.
// The initiator drives start and both operands; the unit returns the packed
// result, a one-cycle completion pulse and a busy level.
interface fpu_mul_if;
  logic        start;
  logic [31:0] a_operand;
  logic [31:0] b_operand;
  logic [31:0] ieee_packet_out;
  logic        cmd_end;
  logic        busy;

  modport master (
    output start,
    output a_operand,
    output b_operand,
    input  ieee_packet_out,
    input  cmd_end,
    input  busy
  );

  modport slave (
    input  start,
    input  a_operand,
    input  b_operand,
    output ieee_packet_out,
    output cmd_end,
    output busy
  );
endinterface

// File: rtl/fpu_mul.sv
// Multi-cycle IEEE-754 binary32 multiplier.
// Significands are multiplied by a serial shift-add loop (one multiplier bit
// per clock). Results are rounded to nearest-even. Subnormal inputs are treated
// as zero and underflowing results flush to signed zero.
module fpu_mul (
  input  logic     clk,
  input  logic     arst,
  fpu_mul_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StUnpack,
    StMult,
    StNorm,
    StRound,
    StDone,
    StWaitLow
  } state_e;

  localparam logic [31:0] QNaN = 32'h7FC0_0000;

  state_e             r_state;
  logic [31:0]        r_a;
  logic [31:0]        r_b;
  logic               r_sign;
  logic signed [9:0]  r_exp;
  logic [47:0]        r_mcand;
  logic [23:0]        r_mplier;
  logic [47:0]        r_prod;
  logic [4:0]         r_count;
  logic [23:0]        r_sig;
  logic               r_guard;
  logic               r_sticky;
  logic [31:0]        r_result;
  logic               r_cmd_end;
  logic               r_busy;

  // Field decode of the latched operands.
  logic [7:0]         w_ea;
  logic [7:0]         w_eb;
  logic [22:0]        w_ma;
  logic [22:0]        w_mb;
  logic               w_sign;
  logic               w_a_nan;
  logic               w_b_nan;
  logic               w_a_inf;
  logic               w_b_inf;
  logic               w_a_zero;
  logic               w_b_zero;
  logic signed [9:0]  w_exp_sum;

  assign w_ea      = r_a[30:23];
  assign w_eb      = r_b[30:23];
  assign w_ma      = r_a[22:0];
  assign w_mb      = r_b[22:0];
  assign w_sign    = r_a[31] ^ r_b[31];
  assign w_a_nan   = (w_ea == 8'hFF) && (w_ma != 23'd0);
  assign w_b_nan   = (w_eb == 8'hFF) && (w_mb != 23'd0);
  assign w_a_inf   = (w_ea == 8'hFF) && (w_ma == 23'd0);
  assign w_b_inf   = (w_eb == 8'hFF) && (w_mb == 23'd0);
  // Exponent 0 covers both true zero and subnormals, which are flushed.
  assign w_a_zero  = (w_ea == 8'h00);
  assign w_b_zero  = (w_eb == 8'h00);
  assign w_exp_sum = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - 10'sd127;

  logic        w_special;
  logic [31:0] w_special_res;

  // Classify special operand combinations that bypass the multiply loop.
  always_comb begin
    w_special     = 1'b1;
    w_special_res = 32'd0;
    if (w_a_nan || w_b_nan) begin
      w_special_res = QNaN;
    end else if ((w_a_inf && w_b_zero) || (w_a_zero && w_b_inf)) begin
      w_special_res = QNaN;
    end else if (w_a_inf || w_b_inf) begin
      w_special_res = {w_sign, 8'hFF, 23'd0};
    end else if (w_a_zero || w_b_zero) begin
      w_special_res = {w_sign, 31'd0};
    end else begin
      w_special = 1'b0;
    end
  end

  logic [47:0] w_prod_next;

  // One shift-add step: add the shifted multiplicand when the current
  // multiplier LSB is set.
  always_comb begin
    w_prod_next = r_prod;
    if (r_mplier[0]) begin
      w_prod_next = r_prod + r_mcand;
    end
  end

  logic [23:0]       w_norm_sig;
  logic              w_norm_guard;
  logic              w_norm_sticky;
  logic signed [9:0] w_norm_exp;

  // Align the 48-bit product so the leading one lands in significand bit 23.
  always_comb begin
    if (r_prod[47]) begin
      w_norm_sig    = r_prod[47:24];
      w_norm_guard  = r_prod[23];
      w_norm_sticky = |r_prod[22:0];
      w_norm_exp    = r_exp + 10'sd1;
    end else begin
      w_norm_sig    = r_prod[46:23];
      w_norm_guard  = r_prod[22];
      w_norm_sticky = |r_prod[21:0];
      w_norm_exp    = r_exp;
    end
  end

  logic              w_round_up;
  logic [24:0]       w_sig_rnd;
  logic [22:0]       w_fin_man;
  logic signed [9:0] w_fin_exp;
  logic [31:0]       w_round_res;

  // Round to nearest-even, renormalise on carry-out, then saturate to
  // infinity or flush to signed zero when the exponent leaves the normal range.
  always_comb begin
    w_round_up = r_guard & (r_sticky | r_sig[0]);
    w_sig_rnd  = {1'b0, r_sig} + {24'd0, w_round_up};
    if (w_sig_rnd[24]) begin
      w_fin_man = w_sig_rnd[23:1];
      w_fin_exp = r_exp + 10'sd1;
    end else begin
      w_fin_man = w_sig_rnd[22:0];
      w_fin_exp = r_exp;
    end
    if (w_fin_exp >= 10'sd255) begin
      w_round_res = {r_sign, 8'hFF, 23'd0};
    end else if (w_fin_exp <= 10'sd0) begin
      w_round_res = {r_sign, 31'd0};
    end else begin
      w_round_res = {r_sign, w_fin_exp[7:0], w_fin_man};
    end
  end

  // Command sequencer and datapath registers; all outputs are registered.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_state   <= StIdle;
      r_a       <= 32'd0;
      r_b       <= 32'd0;
      r_sign    <= 1'b0;
      r_exp     <= 10'sd0;
      r_mcand   <= 48'd0;
      r_mplier  <= 24'd0;
      r_prod    <= 48'd0;
      r_count   <= 5'd0;
      r_sig     <= 24'd0;
      r_guard   <= 1'b0;
      r_sticky  <= 1'b0;
      r_result  <= 32'd0;
      r_cmd_end <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (bus.start) begin
            r_a     <= bus.a_operand;
            r_b     <= bus.b_operand;
            r_busy  <= 1'b1;
            r_state <= StUnpack;
          end
        end
        StUnpack: begin
          if (w_special) begin
            r_result  <= w_special_res;
            r_cmd_end <= 1'b1;
            r_state   <= StDone;
          end else begin
            r_sign   <= w_sign;
            r_exp    <= w_exp_sum;
            r_mcand  <= {24'd0, 1'b1, w_ma};
            r_mplier <= {1'b1, w_mb};
            r_prod   <= 48'd0;
            r_count  <= 5'd23;
            r_state  <= StMult;
          end
        end
        StMult: begin
          r_prod   <= w_prod_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count - 5'd1;
          if (r_count == 5'd0) begin
            r_state <= StNorm;
          end
        end
        StNorm: begin
          r_sig    <= w_norm_sig;
          r_guard  <= w_norm_guard;
          r_sticky <= w_norm_sticky;
          r_exp    <= w_norm_exp;
          r_state  <= StRound;
        end
        StRound: begin
          r_result  <= w_round_res;
          r_cmd_end <= 1'b1;
          r_state   <= StDone;
        end
        StDone: begin
          r_cmd_end <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= StWaitLow;
        end
        StWaitLow: begin
          // A held start must drop before another command is accepted.
          if (!bus.start) begin
            r_state <= StIdle;
          end
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign bus.ieee_packet_out = r_result;
  assign bus.cmd_end         = r_cmd_end;
  assign bus.busy            = r_busy;

endmodule

// File: tb/tb_fpu_mul.sv
// Self-checking bench for fpu_mul: scoreboard of expected results, one task
// per scenario.
module tb_fpu_mul;

  logic clk;
  logic arst;

  fpu_mul_if bus ();

  fpu_mul u_dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] sb[$];

  // Drive a command, record its expected result, consume the accepting edge
  // and then scramble the operands (they must already be latched).
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_res);
    @(negedge clk);
    bus.a_operand = a;
    bus.b_operand = b;
    bus.start     = 1'b1;
    sb.push_back(exp_res);
    @(posedge clk);
    #1;
    bus.a_operand = $urandom;
    bus.b_operand = $urandom;
  endtask

  // Count edges after the accepting edge until cmd_end; -1 if it never comes.
  task automatic wait_done(output int edges);
    edges = -1;
    for (int e = 1; e <= 100; e++) begin
      @(posedge clk);
      #1;
      if (bus.cmd_end) begin
        edges = e;
        return;
      end
    end
  endtask

  task automatic finish_op();
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    arst          = 1'b0;
    bus.start     = 1'b0;
    bus.a_operand = 32'd0;
    bus.b_operand = 32'd0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy got %b exp 0", bus.busy);
    end
    n_tests++;
    if (bus.cmd_end !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_cmd_end got %b exp 0", bus.cmd_end);
    end
    n_tests++;
    if (bus.ieee_packet_out !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_out got %h exp 00000000", bus.ieee_packet_out);
    end
    arst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int          busy_cnt = 0;
    int          end_cnt  = 0;
    int          end_edge = -1;
    logic [31:0] exp_res;
    issue(32'h3f800000, 32'h3f8ccccd, 32'h3f8ccccd);
    if (bus.busy) busy_cnt++;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (bus.busy) busy_cnt++;
      if (bus.cmd_end) begin
        end_cnt++;
        if (end_cnt == 1) end_edge = e;
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL basic_unexpected_end got result %h exp none", bus.ieee_packet_out);
        end else begin
          exp_res = sb.pop_front();
          if (bus.ieee_packet_out !== exp_res) begin
            n_fail++;
            $display("FAIL basic_result got %h exp %h", bus.ieee_packet_out, exp_res);
          end
        end
        bus.start = 1'b0;
      end
    end
    n_tests++;
    if (end_edge != 27) begin
      n_fail++;
      $display("FAIL basic_latency got %0d exp 27", end_edge);
    end
    n_tests++;
    if (end_cnt != 1) begin
      n_fail++;
      $display("FAIL basic_end_pulses got %0d exp 1", end_cnt);
    end
    n_tests++;
    if (busy_cnt != 28) begin
      n_fail++;
      $display("FAIL basic_busy_cycles got %0d exp 28", busy_cnt);
    end
    finish_op();
  endtask

  task automatic test_exact_held();
    int          edges;
    int          extra_end = 0;
    int          extra_busy = 0;
    logic [31:0] exp_res;
    issue(32'h41800000, 32'h42000000, 32'h44000000);
    wait_done(edges);
    exp_res = sb.pop_front();
    n_tests++;
    if (edges != 27 || bus.ieee_packet_out !== exp_res) begin
      n_fail++;
      $display("FAIL exact_16x32 got %h at edge %0d exp %h at edge 27",
               bus.ieee_packet_out, edges, exp_res);
    end
    // start stays high: the unit must not re-trigger.
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.cmd_end) extra_end++;
      if (bus.busy) extra_busy++;
    end
    n_tests++;
    if (extra_end != 0 || extra_busy != 0) begin
      n_fail++;
      $display("FAIL held_start got %0d ends %0d busy exp 0 0", extra_end, extra_busy);
    end
    n_tests++;
    if (bus.ieee_packet_out !== 32'h44000000) begin
      n_fail++;
      $display("FAIL held_result got %h exp 44000000", bus.ieee_packet_out);
    end
    finish_op();
    issue(32'h3e800000, 32'h3f000000, 32'h3e000000);
    wait_done(edges);
    exp_res = sb.pop_front();
    n_tests++;
    if (edges != 27 || bus.ieee_packet_out !== exp_res) begin
      n_fail++;
      $display("FAIL exact_quarter_half got %h at edge %0d exp %h at edge 27",
               bus.ieee_packet_out, edges, exp_res);
    end
    finish_op();
  endtask

  task automatic test_rne_overflow();
    logic [31:0] va[2] = '{32'h3f800001, 32'h7f7fffff};
    logic [31:0] vb[2] = '{32'h3f800001, 32'h40000000};
    logic [31:0] vr[2] = '{32'h3f800002, 32'h7f800000};
    int          edges;
    logic [31:0] exp_res;
    for (int i = 0; i < 2; i++) begin
      issue(va[i], vb[i], vr[i]);
      wait_done(edges);
      exp_res = sb.pop_front();
      n_tests++;
      if (edges != 27 || bus.ieee_packet_out !== exp_res) begin
        n_fail++;
        $display("FAIL rne_ovf_%0d got %h at edge %0d exp %h at edge 27",
                 i, bus.ieee_packet_out, edges, exp_res);
      end
      finish_op();
    end
  endtask

  task automatic test_special();
    logic [31:0] va[4] = '{32'h7F800000, 32'hFF800000, 32'hFF800000, 32'h7FC00000};
    logic [31:0] vb[4] = '{32'h00000000, 32'h41200000, 32'hFF800000, 32'h402df854};
    logic [31:0] vr[4] = '{32'h7FC00000, 32'hFF800000, 32'h7F800000, 32'h7FC00000};
    int          edges;
    logic [31:0] exp_res;
    for (int i = 0; i < 4; i++) begin
      issue(va[i], vb[i], vr[i]);
      wait_done(edges);
      exp_res = sb.pop_front();
      n_tests++;
      if (edges != 1 || bus.ieee_packet_out !== exp_res) begin
        n_fail++;
        $display("FAIL special_%0d got %h at edge %0d exp %h at edge 1",
                 i, bus.ieee_packet_out, edges, exp_res);
      end
      @(posedge clk);
      #1;
      n_tests++;
      if (bus.cmd_end !== 1'b0 || bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL special_end_%0d got cmd_end %b busy %b exp 0 0",
                 i, bus.cmd_end, bus.busy);
      end
      finish_op();
    end
  endtask

  task automatic test_subnormal();
    int          edges;
    logic [31:0] exp_res;
    issue(32'h3f800000, 32'h00000001, 32'h00000000);
    wait_done(edges);
    exp_res = sb.pop_front();
    n_tests++;
    if (edges != 1 || bus.ieee_packet_out !== exp_res) begin
      n_fail++;
      $display("FAIL ftz_input got %h at edge %0d exp %h at edge 1",
               bus.ieee_packet_out, edges, exp_res);
    end
    finish_op();
    issue(32'h80800000, 32'h00800000, 32'h80000000);
    wait_done(edges);
    exp_res = sb.pop_front();
    n_tests++;
    if (edges != 27 || bus.ieee_packet_out !== exp_res) begin
      n_fail++;
      $display("FAIL underflow got %h at edge %0d exp %h at edge 27",
               bus.ieee_packet_out, edges, exp_res);
    end
    finish_op();
  endtask

  task automatic test_async_reset();
    int          edges;
    logic [31:0] exp_res;
    issue(32'h41800000, 32'h42000000, 32'h44000000);
    repeat (10) @(posedge clk);
    #2;
    arst = 1'b0;
    #1;
    // The operation in flight is discarded.
    sb.delete();
    n_tests++;
    if (bus.busy !== 1'b0 || bus.cmd_end !== 1'b0 || bus.ieee_packet_out !== 32'd0) begin
      n_fail++;
      $display("FAIL async_reset got busy %b cmd_end %b out %h exp 0 0 00000000",
               bus.busy, bus.cmd_end, bus.ieee_packet_out);
    end
    bus.a_operand = 32'h3e800000;
    bus.b_operand = 32'h3f000000;
    sb.push_back(32'h3e000000);
    repeat (2) @(negedge clk);
    arst = 1'b1;
    @(posedge clk);
    #1;
    wait_done(edges);
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL post_reset_sb got empty exp one entry");
    end else begin
      exp_res = sb.pop_front();
      if (edges != 27 || bus.ieee_packet_out !== exp_res) begin
        n_fail++;
        $display("FAIL post_reset_op got %h at edge %0d exp %h at edge 27",
                 bus.ieee_packet_out, edges, exp_res);
      end
    end
    finish_op();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_exact_held();
    test_rne_overflow();
    test_special();
    test_subnormal();
    test_async_reset();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover got %0d exp 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
